// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// Round-robin arbiter that lets NUM_CORES cores share one single-port data
// memory. One access is in flight at a time and takes three cycles:
//   IDLE  -> a winner is chosen among the requesting cores
//   ISSUE -> the winner's we/addr/wdata appear on mem_* with mem_en = 1
//   RESP  -> ack[winner] pulses and rdata carries mem_rdata
//
// Build option:
//   DM_ARB_LOCK_EN - when defined, a core acked while holding lock[i] becomes
//                    the lock owner and is the only eligible requester until
//                    an IDLE cycle sees its lock bit low. When undefined the
//                    lock port is present but ignored.
//
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   req        - per-core request (level, held until ack)
//   we         - per-core write enable, valid with req
//   lock       - per-core ownership hold (DM_ARB_LOCK_EN only)
//   addr       - packed addresses, core i at [i*ADDR_W +: ADDR_W]
//   wdata      - packed write data, core i at [i*DATA_W +: DATA_W]
//   gnt        - one-hot registered grant, high during ISSUE and RESP
//   ack        - one-hot one-cycle completion pulse (RESP)
//   rdata      - read data, meaningful only while ack is non-zero
//   mem_en     - memory access strobe (registered, ISSUE only)
//   mem_we     - memory write strobe (registered, ISSUE only)
//   mem_addr   - memory address (registered)
//   mem_wdata  - memory write data (registered)
//   mem_rdata  - memory read data, one cycle after mem_en
// -----------------------------------------------------------------------------
module dm_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES-1:0]        lock,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     last;        // most recently granted core
    logic [IDX_W-1:0]     cur;         // core being served
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand;
    logic                 pick_valid;
    logic [NUM_CORES-1:0] eligible;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

`ifdef DM_ARB_LOCK_EN
    logic             owner_valid;
    logic [IDX_W-1:0] owner;
    logic             owner_hold;

    // While the owner keeps its lock asserted, every other requester is masked.
    assign owner_hold = owner_valid && lock[owner];
    assign eligible   = owner_hold ? (req & (NUM_CORES'(1) << owner)) : req;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_valid <= 1'b0;
            owner       <= '0;
        end else if (state == IDLE && owner_valid && !lock[owner]) begin
            // Release happens in the same IDLE cycle that arbitrates normally.
            owner_valid <= 1'b0;
        end else if (state == RESP && lock[cur]) begin
            owner_valid <= 1'b1;
            owner       <= cur;
        end
    end
`else
    logic lock_unused;
    assign lock_unused = ^lock;
    assign eligible    = req;
`endif

    // Round-robin search starting at last+1. Walking from the farthest
    // candidate back to the nearest lets the nearest eligible core overwrite.
    // NOTE: every signal written here gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last;
        cand       = last;
        for (int i = NUM_CORES; i >= 1; i--) begin
            cand = IDX_W'((int'(last) + i) % NUM_CORES);
            if (eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign sel_addr  = ADDR_W'(addr  >> (int'(pick_idx) * ADDR_W));
    assign sel_wdata = DATA_W'(wdata >> (int'(pick_idx) * DATA_W));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= '0;
            ack       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            last      <= IDX_W'(NUM_CORES - 1);
            cur       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt       <= NUM_CORES'(1) << pick_idx;
                        mem_en    <= 1'b1;
                        mem_we    <= we[pick_idx];
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        last      <= pick_idx;
                        cur       <= pick_idx;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    ack    <= gnt;
                end
                RESP: begin
                    ack <= '0;
                    gnt <= '0;
                end
                default: begin
                    gnt <= '0;
                    ack <= '0;
                end
            endcase
        end
    end

    // The memory presents read data in the RESP cycle; pass it straight through.
    assign rdata = mem_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
//
// Self-checking bench for dm_arbiter (4 cores, 16-bit address/data). A
// behavioural model tracks which core owns the memory and for how long,
// applies the round-robin and lock rules, and keeps its own copy of memory.
// A compare process checks every DUT output against the model on each
// negative clock edge. Directed scenarios pin the model with literal values,
// then randomized requesters exercise contention, writes and reset pulses.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
`ifdef DM_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    logic [AW-1:0]   a_arr [N];
    logic [DW-1:0]   d_arr [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign addr[g*AW +: AW]  = a_arr[g];
        assign wdata[g*DW +: DW] = d_arr[g];
    end

    dm_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc     = 0;
    int n_check = 0;
    int n_pass  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- memory attached to the DUT's mem_* port ----------------
    logic [DW-1:0] env_mem [0:(1<<AW)-1];
    logic [DW-1:0] mdl_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr] <= mem_wdata;
            mem_rdata <= env_mem[mem_addr];
        end
    end

    // ---------------- behavioural model ----------------
    // ph counts cycles of the current access: 0 = free, 1 = issue, 2 = response.
    bit            m_run = 1'b0;
    int            ph    = 0;
    logic [1:0]    m_cur, m_last, m_own;
    bit            m_own_v;
    bit            m_clean;    // no access issued since reset
    logic          x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata, x_rdata;

    always @(posedge clk) begin : model
        automatic bit         hold;
        automatic bit         found;
        automatic logic [1:0] c;
        automatic logic [1:0] w;
        if (rst) begin
            m_run   <= 1'b1;
            ph      <= 0;
            m_last  <= 2'(N - 1);
            m_cur   <= 2'd0;
            m_own_v <= 1'b0;
            m_clean <= 1'b1;
        end else if (m_run) begin
            if (ph == 0) begin
                hold  = LOCK && m_own_v && lock[m_own];
                if (LOCK && m_own_v && !lock[m_own]) m_own_v <= 1'b0;
                found = 1'b0;
                w     = 2'd0;
                for (int k = 1; k <= N; k++) begin
                    c = 2'((int'(m_last) + k) % N);
                    if (!found && req[c] && (!hold || c == m_own)) begin
                        found = 1'b1;
                        w     = c;
                    end
                end
                if (found) begin
                    ph      <= 1;
                    m_cur   <= w;
                    m_last  <= w;
                    m_clean <= 1'b0;
                    x_we    <= we[w];
                    x_addr  <= a_arr[w];
                    x_wdata <= d_arr[w];
                    if (we[w]) mdl_mem[a_arr[w]] <= d_arr[w];
                    else       x_rdata <= mdl_mem[a_arr[w]];
                end
            end else if (ph == 1) begin
                ph <= 2;
            end else begin
                if (LOCK && lock[m_cur]) begin
                    m_own_v <= 1'b1;
                    m_own   <= m_cur;
                end
                ph <= 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        automatic logic [N-1:0] e_gnt;
        automatic logic [N-1:0] e_ack;
        if (m_run) begin
            e_gnt = (ph != 0) ? (N'(1) << m_cur) : '0;
            e_ack = (ph == 2) ? (N'(1) << m_cur) : '0;
            check("gnt",    32'(gnt),    32'(e_gnt));
            check("ack",    32'(ack),    32'(e_ack));
            check("mem_en", 32'(mem_en), 32'(ph == 1));
            check("mem_we", 32'(mem_we), 32'(ph == 1 && x_we));
            if (ph == 1) begin
                check("mem_addr",  32'(mem_addr),  32'(x_addr));
                if (x_we) check("mem_wdata", 32'(mem_wdata), 32'(x_wdata));
            end
            if (ph == 2 && !x_we) check("rdata", 32'(rdata), 32'(x_rdata));
            if (ph == 0 && m_clean) begin
                check("mem_addr_rst",  32'(mem_addr),  32'd0);
                check("mem_wdata_rst", 32'(mem_wdata), 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic raise(input logic [1:0] c, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        req[c]   = 1'b1;
        we[c]    = w;
        a_arr[c] = a;
        d_arr[c] = d;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        we   = '0;
        lock = '0;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            d_arr[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Waits (bounded) for the next ack; a timeout returns ack = 0.
    task automatic wait_ack(output logic [N-1:0] a, output int t, output logic [DW-1:0] d);
        a = '0;
        t = 0;
        d = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                a = ack;
                t = cyc;
                d = rdata;
                return;
            end
        end
    endtask

    task automatic drop(input logic [1:0] c);
        @(posedge clk);
        #1 req[c] = 1'b0;
    endtask

    initial begin
        logic [N-1:0]  a;
        logic [DW-1:0] d;
        int            t, t0;

        for (int i = 0; i < (1 << AW); i++) begin
            env_mem[i] = DW'(i * 7 + 3);
            mdl_mem[i] = DW'(i * 7 + 3);
        end
        env_mem[16'h0010] = 16'hBEEF;
        mdl_mem[16'h0010] = 16'hBEEF;

        // Reset state.
        do_reset();
        @(negedge clk);
        check("rst_gnt",    32'(gnt),      32'h0);
        check("rst_ack",    32'(ack),      32'h0);
        check("rst_mem_en", 32'(mem_en),   32'h0);
        check("rst_addr",   32'(mem_addr), 32'h0);

        // Single read by core 1.
        @(posedge clk);
        #1 raise(2'd1, 1'b0, 16'h0010, 16'h0);
        repeat (2) @(negedge clk);
        check("t1_mem_en", 32'(mem_en),   32'h1);
        check("t1_gnt",    32'(gnt),      32'b0010);
        check("t1_addr",   32'(mem_addr), 32'h0010);
        @(negedge clk);
        check("t1_ack",    32'(ack),      32'b0010);
        check("t1_rdata",  32'(rdata),    32'hBEEF);
        drop(2'd1);

        // All four cores at once: 0,1,2,3 spaced by 3 cycles.
        do_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) raise(2'(i), 1'b0, AW'(16'h0100 + i), 16'h0);
        t0 = cyc;
        for (int k = 0; k < N; k++) begin
            wait_ack(a, t, d);
            check("all4_ack",    32'(a),  32'(N'(1) << k));
            check("all4_timing", 32'(t - t0), 32'(2 + 3 * k));
            drop(2'(k));
        end

        // Rotation: after core 2, core 3 beats core 0.
        do_reset();
        @(posedge clk);
        #1 raise(2'd2, 1'b0, 16'h0020, 16'h0);
        wait_ack(a, t, d);
        check("rot_first", 32'(a), 32'b0100);
        drop(2'd2);
        @(posedge clk);
        #1;
        raise(2'd0, 1'b0, 16'h0030, 16'h0);
        raise(2'd3, 1'b0, 16'h0031, 16'h0);
        wait_ack(a, t, d);
        check("rot_c3", 32'(a), 32'b1000);
        drop(2'd3);
        wait_ack(a, t, d);
        check("rot_c0", 32'(a), 32'b0001);
        drop(2'd0);

        // Write then read back.
        do_reset();
        @(posedge clk);
        #1 raise(2'd0, 1'b1, 16'h0042, 16'h1234);
        repeat (2) @(negedge clk);
        check("wr_mem_we",    32'(mem_we),    32'h1);
        check("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
        @(negedge clk);
        check("wr_ack", 32'(ack), 32'b0001);
        drop(2'd0);
        @(posedge clk);
        #1 raise(2'd0, 1'b0, 16'h0042, 16'h0);
        wait_ack(a, t, d);
        check("rd_ack",   32'(a), 32'b0001);
        check("rd_rdata", 32'(d), 32'h1234);
        drop(2'd0);

        // Reset during ISSUE of core 2; re-request served from core 0 priority.
        do_reset();
        @(posedge clk);
        #1 raise(2'd1, 1'b0, 16'h0050, 16'h0);
        wait_ack(a, t, d);
        drop(2'd1);
        @(posedge clk);
        #1;
        raise(2'd2, 1'b0, 16'h0051, 16'h0);
        raise(2'd3, 1'b0, 16'h0052, 16'h0);
        repeat (2) @(negedge clk);
        check("rs_issue_gnt", 32'(gnt), 32'b0100);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rs_gnt",    32'(gnt),    32'h0);
        check("rs_mem_en", 32'(mem_en), 32'h0);
        check("rs_ack",    32'(ack),    32'h0);
        wait_ack(a, t, d);
        check("rs_regrant", 32'(a), 32'b0100);
        drop(2'd2);
        wait_ack(a, t, d);
        check("rs_next", 32'(a), 32'b1000);
        drop(2'd3);

`ifdef DM_ARB_LOCK_EN
        // Locked read-modify-write by core 1 while core 0 waits.
        do_reset();
        @(posedge clk);
        #1;
        raise(2'd1, 1'b0, 16'h0060, 16'h0);
        lock[1] = 1'b1;
        repeat (2) @(negedge clk);
        raise(2'd0, 1'b0, 16'h0061, 16'h0);
        wait_ack(a, t, d);
        check("lk_read", 32'(a), 32'b0010);
        drop(2'd1);
        @(posedge clk);
        #1 raise(2'd1, 1'b1, 16'h0060, 16'h5555);
        wait_ack(a, t, d);
        check("lk_write_first", 32'(a), 32'b0010);
        @(posedge clk);
        #1;
        req[1]  = 1'b0;
        lock[1] = 1'b0;
        wait_ack(a, t, d);
        check("lk_release", 32'(a), 32'b0001);
        drop(2'd0);
`endif

        // Randomized requesters with occasional reset pulses.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            a = ack;
            @(posedge clk);
            #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (a[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0)
                    raise(2'(i), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                          DW'($urandom));
                if ($urandom_range(0, 7) == 0) lock[i] = ~lock[i];
            end
        end
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Round-robin arbiter that lets `NUM_CORES` processor cores share one single-port data memory. Each core raises a request with address, write data and write enable. The arbiter grants one core at a time and drives the shared memory port. It returns read data with a one-cycle acknowledge. It sits between the per-core memory interfaces (`AR_out`, `bus`, `DM_write_en`) and the shared DM instance in the multi-core top level.

## Interface
Parameters:
- `NUM_CORES`, default 4: number of requesting cores, 2..8.
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 16: memory data width.

Ports:
- `clk` in 1: single system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `NUM_CORES`: per-core access request, level.
- `we` in `NUM_CORES`: per-core write enable, valid while `req[i]`=1.
- `lock` in `NUM_CORES`: per-core ownership hold. Used only with `DM_ARB_LOCK_EN`.
- `addr` in `NUM_CORES*ADDR_W`: packed addresses; core i occupies bits `[i*ADDR_W +: ADDR_W]`.
- `wdata` in `NUM_CORES*DATA_W`: packed write data, same packing as `addr`.
- `gnt` out `NUM_CORES`: one-hot, registered; the core currently being served.
- `ack` out `NUM_CORES`: one-hot, one-cycle pulse; the access is complete.
- `rdata` out `DATA_W`: read data, valid only while some `ack` bit = 1.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_rdata` in `DATA_W`: memory read data, one cycle after `mem_en`.

## Operation
- FSM states:
  - IDLE: if any eligible `req`, pick a winner and go to ISSUE; else stay.
  - ISSUE: the winner's `we`/`addr`/`wdata` are driven on `mem_*` with `mem_en`=1; go to RESP.
  - RESP: `ack[winner]`=1 and `rdata`=`mem_rdata`; go to IDLE.
- Arbitration: round-robin. The search starts at `(last+1) mod NUM_CORES`; the first core with `req`=1 wins. `last` is set to the winner on the IDLE→ISSUE transition.
- Requester rules:
  - Hold `req`, `we`, `addr` and `wdata` stable from assertion until the `ack` cycle.
  - Deassert `req` in the cycle after `ack`; `req` still high in IDLE counts as a new request.
- Write accesses also complete with `ack`; `rdata` is don't-care for writes.
- `req` dropped before `ack` (protocol violation): the access still completes and `ack` still pulses.
- Requests arriving in ISSUE or RESP wait for the next IDLE.
- Reset values:
  - state IDLE; `gnt`, `ack` = 0.
  - `mem_en`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0.
  - `last` = `NUM_CORES-1`, so core 0 has first priority.
  - no lock owner.
- Reset mid-access: any state returns to IDLE on the next edge with all outputs at reset values. An in-flight `ack` is not issued, and the core must re-request.

## Timing
- Request seen in IDLE at edge k → `gnt`/`mem_en` high in cycle k+1 (ISSUE) → `ack`/`rdata` in cycle k+2 (RESP) → IDLE in k+3.
- Latency from `req` to `ack` is 2 cycles when uncontended. One access completes per 3 cycles.
- `gnt` is high during ISSUE and RESP.
- `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are registered outputs, valid only in ISSUE.
- `rdata` is combinational from `mem_rdata`. The memory must present read data in the cycle after `mem_en`.

## Configuration
- Macro `DM_ARB_LOCK_EN`.
- Defined:
  - A core acked with `lock[i]`=1 becomes the lock owner.
  - While `lock[owner]`=1, only the owner is eligible in IDLE; other requests wait, and the round-robin pointer is not advanced for them.
  - Ownership is released in the first IDLE cycle that sees `lock[owner]`=0; normal arbitration resumes that same cycle.
  - This supports atomic read-modify-write.
- Undefined: the `lock` port exists but is ignored, and there is no owner register.

## Test plan
- Single read, core 1: `req[1]`=1, `addr`=0x0010, memory word 0x0010 = 0xBEEF → `mem_en` in cycle 1, `ack`=4'b0010 with `rdata`=0xBEEF in cycle 2.
- Simultaneous requests from all 4 cores, held until ack → `gnt` sequence 0001, 0010, 0100, 1000, each spaced 3 cycles; each `ack` goes to the matching core.
- Rotation: core 2 served, then `req[0]` and `req[3]` raised together → core 3 is granted before core 0.
- Write: core 0 writes 0x1234 to 0x0042, then reads 0x0042 → `mem_we`=1 during the first ISSUE; the read acks with `rdata`=0x1234.
- `rst` pulsed during ISSUE of core 2 → next cycle `gnt`=0, `mem_en`=0, no `ack`; the re-request is served from core 0 priority.
- `DM_ARB_LOCK_EN` defined:
  - Core 1 reads with `lock[1]`=1 while core 0 keeps requesting → core 1's following write is granted before core 0.
  - After `lock[1]` drops, core 0 is granted.
